// File: rtl/data_unshuffler3.sv
// 3-parallel delay-commutator un-shuffler: 3x3 transpose of D-beat segments, latency 2*D accepted beats.
// in_valid=0 freezes every register; b0..b2 hold and out_valid/out_sop drop for that cycle.
module data_unshuffler3 #(
  parameter int W = 32,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_sop,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] a2,
  output logic         out_valid,
  output logic         out_sop,
  output logic [W-1:0] b0,
  output logic [W-1:0] b1,
  output logic [W-1:0] b2
);

  localparam int BW = (D > 1) ? $clog2(D) : 1;
  localparam int FW = $clog2(2 * D + 1);
  localparam int L2 = 2 * D;

  logic [BW-1:0] r_beat_cnt;
  logic [1:0]    r_seg_cnt;
  logic [FW-1:0] r_fill_cnt;
  logic [W-1:0]  r_pre1  [D];
  logic [W-1:0]  r_pre2  [L2];
  logic [W-1:0]  r_post0 [L2];
  logic [W-1:0]  r_post1 [D];
  logic [L2-1:0] r_sop_dly;

  logic [BW-1:0] w_beat;
  logic [1:0]    w_seg;
  logic          w_fill_full;
  logic [W-1:0]  w_y0, w_y1, w_y2;
  logic [W-1:0]  w_z0, w_z1, w_z2;

  // in_sop pins the current beat to beat 0 of segment 0 before the counters are consulted
  always_comb begin
    w_beat      = in_sop ? '0 : r_beat_cnt;
    w_seg       = in_sop ? 2'd0 : r_seg_cnt;
    w_fill_full = (r_fill_cnt == FW'(L2));
    w_y0        = a0;
    w_y1        = r_pre1[D-1];
    w_y2        = r_pre2[L2-1];
  end

  always_comb begin
    w_z0 = w_y0;
    w_z1 = w_y2;
    w_z2 = w_y1;
    case (w_seg)
      2'd1: begin
        w_z0 = w_y1;
        w_z1 = w_y0;
        w_z2 = w_y2;
      end
      2'd2: begin
        w_z0 = w_y2;
        w_z1 = w_y1;
        w_z2 = w_y0;
      end
      default: begin
        w_z0 = w_y0;
        w_z1 = w_y2;
        w_z2 = w_y1;
      end
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_seg_cnt  <= 2'd0;
      r_fill_cnt <= '0;
    end else if (in_valid) begin
      if (w_beat == BW'(D - 1)) begin
        r_beat_cnt <= '0;
        r_seg_cnt  <= (w_seg == 2'd2) ? 2'd0 : w_seg + 2'd1;
      end else begin
        r_beat_cnt <= w_beat + BW'(1);
        r_seg_cnt  <= w_seg;
      end
      if (!w_fill_full) r_fill_cnt <= r_fill_cnt + FW'(1);
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) begin
        r_pre1[i]  <= '0;
        r_post1[i] <= '0;
      end
      for (int i = 0; i < L2; i++) begin
        r_pre2[i]  <= '0;
        r_post0[i] <= '0;
      end
      r_sop_dly <= '0;
    end else if (in_valid) begin
      r_pre1[0]  <= a1;
      r_post1[0] <= w_z1;
      for (int i = 1; i < D; i++) begin
        r_pre1[i]  <= r_pre1[i-1];
        r_post1[i] <= r_post1[i-1];
      end
      r_pre2[0]  <= a2;
      r_post0[0] <= w_z0;
      for (int i = 1; i < L2; i++) begin
        r_pre2[i]  <= r_pre2[i-1];
        r_post0[i] <= r_post0[i-1];
      end
      r_sop_dly <= {r_sop_dly[L2-2:0], in_sop};
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      b0        <= '0;
      b1        <= '0;
      b2        <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
    end else if (in_valid) begin
      b0        <= r_post0[L2-1];
      b1        <= r_post1[D-1];
      b2        <= w_z2;
      out_valid <= w_fill_full;
      out_sop   <= r_sop_dly[L2-1] & w_fill_full;
    end else begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
    end
  end

endmodule
